// File: rtl/char_matcher.sv
// Streaming KMP matcher: reports every (overlapping) occurrence of PAT in an
// accepted byte stream, resolving each character in one cycle.
module char_matcher #(
   parameter int                   PAT_LEN = 10,
   parameter logic [8*PAT_LEN-1:0] PAT     = "JUSTMONIKA",
   parameter int                   CNT_W   = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clr,
   input  logic                           in_valid,
   input  logic [7:0]                     in_char,
   output logic                           match,
   output logic [CNT_W-1:0]               match_pos,
   output logic [CNT_W-1:0]               match_cnt,
   output logic [$clog2(PAT_LEN+1)-1:0]   prefix_len
);

   localparam int PW = $clog2(PAT_LEN + 1);
   // Fixed 6-bit entries hold any prefix length 0..32.
   localparam int FW = 6;

   typedef logic [(PAT_LEN+1)*FW-1:0] fail_tab_t;

   function automatic logic [7:0] pat_char(input int i);
      return PAT[8*(PAT_LEN-1-i) +: 8];
   endfunction

   // Entry i is the longest proper border of the first i pattern characters.
   function automatic fail_tab_t build_fail();
      fail_tab_t tab;
      int        k;
      tab = '0;
      k   = 0;
      for (int i = 1; i < PAT_LEN; i++) begin
         while (k > 0 && pat_char(i) != pat_char(k)) begin
            k = int'(tab[k*FW +: FW]);
         end
         if (pat_char(i) == pat_char(k)) begin
            k = k + 1;
         end else begin
            k = k;
         end
         tab[(i+1)*FW +: FW] = FW'(k);
      end
      return tab;
   endfunction

   localparam fail_tab_t       FAIL_TAB  = build_fail();
   localparam logic [FW-1:0]   FAIL_FULL = FAIL_TAB[PAT_LEN*FW +: FW];
   localparam logic [FW-1:0]   FULL_LEN  = FW'(PAT_LEN);

   logic [PW-1:0]    prefix_r;
   logic [CNT_W-1:0] idx_r;
   logic [CNT_W-1:0] pos_r;
   logic [CNT_W-1:0] cnt_r;
   logic             match_r;

   logic [FW-1:0]    cur_s;
   logic [FW-1:0]    adv_s;
   logic             found_s;
   logic             hit_s;
   logic [PW-1:0]    next_prefix_s;

   // Unrolled failure chain: each step either extends the prefix, bottoms out
   // at zero, or falls back; PAT_LEN steps always suffice since cur_s shrinks.
   always_comb begin
      cur_s   = FW'(prefix_r);
      adv_s   = '0;
      found_s = 1'b0;
      for (int j = 0; j < PAT_LEN; j++) begin
         if (found_s) begin
            adv_s = adv_s;
         end else if (pat_char(int'(cur_s)) == in_char) begin
            adv_s   = cur_s + 6'd1;
            found_s = 1'b1;
         end else if (cur_s == 6'd0) begin
            adv_s   = 6'd0;
            found_s = 1'b1;
         end else begin
            cur_s = FAIL_TAB[int'(cur_s)*FW +: FW];
         end
      end
   end

   // Completing the pattern restarts from its longest border, never PAT_LEN.
   always_comb begin
      hit_s = found_s && (adv_s == FULL_LEN);
      if (hit_s) begin
         next_prefix_s = PW'(FAIL_FULL);
      end else begin
         next_prefix_s = PW'(adv_s);
      end
   end

   // Matcher state, stream index and match bookkeeping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prefix_r <= '0;
         idx_r    <= '0;
         pos_r    <= '0;
         cnt_r    <= '0;
         match_r  <= 1'b0;
      end else if (clr) begin
         prefix_r <= '0;
         idx_r    <= '0;
         pos_r    <= '0;
         cnt_r    <= '0;
         match_r  <= 1'b0;
      end else if (in_valid) begin
         prefix_r <= next_prefix_s;
         idx_r    <= idx_r + CNT_W'(1);
         match_r  <= hit_s;
         if (hit_s) begin
            pos_r <= idx_r;
            if (cnt_r != {CNT_W{1'b1}}) begin
               cnt_r <= cnt_r + CNT_W'(1);
            end else begin
               cnt_r <= cnt_r;
            end
         end else begin
            pos_r <= pos_r;
            cnt_r <= cnt_r;
         end
      end else begin
         match_r <= 1'b0;
      end
   end

   assign match      = match_r;
   assign match_pos  = pos_r;
   assign match_cnt  = cnt_r;
   assign prefix_len = prefix_r;

endmodule

// File: tb/tb_char_matcher.sv
// Random and directed stimulus for three matcher configurations sharing one
// input stream, checked against a brute-force string-tail reference model.
module tb_char_matcher;

   logic       clk = 1'b0;
   logic       rst;
   logic       clr;
   logic       in_valid;
   logic [7:0] in_char;

   logic        m0, m1, m2;
   logic [15:0] pos0, pos1, cnt0, cnt1;
   logic [1:0]  pos2, cnt2;
   logic [3:0]  pl0;
   logic [1:0]  pl1;
   logic [0:0]  pl2;

   always #5 clk = ~clk;

   char_matcher u_dflt (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_char(in_char),
      .match(m0), .match_pos(pos0), .match_cnt(cnt0), .prefix_len(pl0));

   char_matcher #(.PAT_LEN(3), .PAT("ABA")) u_aba (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_char(in_char),
      .match(m1), .match_pos(pos1), .match_cnt(cnt1), .prefix_len(pl1));

   char_matcher #(.PAT_LEN(1), .PAT("A"), .CNT_W(2)) u_a (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_char(in_char),
      .match(m2), .match_pos(pos2), .match_cnt(cnt2), .prefix_len(pl2));

   int total_n = 0;
   int bad_n   = 0;

   byte unsigned hist[$];
   int    acc_n;
   string pats[3] = '{"JUSTMONIKA", "ABA", "A"};
   int    cw[3]   = '{16, 16, 2};
   int    exp_pos[3];
   int    exp_cnt[3];
   bit    exp_match[3];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_n++;
      if (got !== exp) begin
         bad_n++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic bit tail_is(input string p, input int n);
      if (n > hist.size()) return 1'b0;
      for (int i = 0; i < n; i++)
         if (hist[hist.size()-n+i] != p[i]) return 1'b0;
      return 1'b1;
   endfunction

   // Longest stream tail shorter than the pattern that is a pattern prefix.
   function automatic int exp_prefix(input int k);
      for (int n = pats[k].len() - 1; n > 0; n--)
         if (tail_is(pats[k], n)) return n;
      return 0;
   endfunction

   task automatic model_clear();
      hist.delete();
      acc_n = 0;
      for (int k = 0; k < 3; k++) begin
         exp_pos[k] = 0; exp_cnt[k] = 0; exp_match[k] = 1'b0;
      end
   endtask

   task automatic model_accept(input byte unsigned c);
      hist.push_back(c);
      if (hist.size() > 64) void'(hist.pop_front());
      for (int k = 0; k < 3; k++) begin
         exp_match[k] = tail_is(pats[k], pats[k].len());
         if (exp_match[k]) begin
            exp_pos[k] = acc_n % (1 << cw[k]);
            if (exp_cnt[k] < (1 << cw[k]) - 1) exp_cnt[k]++;
         end
      end
      acc_n++;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".d.match"}, m0,   exp_match[0]);
      chk({tag, ".d.pos"},   pos0, exp_pos[0]);
      chk({tag, ".d.cnt"},   cnt0, exp_cnt[0]);
      chk({tag, ".d.plen"},  pl0,  exp_prefix(0));
      chk({tag, ".b.match"}, m1,   exp_match[1]);
      chk({tag, ".b.pos"},   pos1, exp_pos[1]);
      chk({tag, ".b.cnt"},   cnt1, exp_cnt[1]);
      chk({tag, ".b.plen"},  pl1,  exp_prefix(1));
      chk({tag, ".a.match"}, m2,   exp_match[2]);
      chk({tag, ".a.pos"},   pos2, exp_pos[2]);
      chk({tag, ".a.cnt"},   cnt2, exp_cnt[2]);
      chk({tag, ".a.plen"},  pl2,  exp_prefix(2));
   endtask

   task automatic step(input string tag, input bit v, input byte unsigned c, input bit cl);
      @(negedge clk);
      in_valid = v; in_char = c; clr = cl;
      @(posedge clk);
      if (cl) model_clear();
      else if (v) model_accept(c);
      else for (int k = 0; k < 3; k++) exp_match[k] = 1'b0;
      #1;
      check_all(tag);
   endtask

   task automatic feed(input string tag, input string s);
      for (int i = 0; i < s.len(); i++) step(tag, 1'b1, s[i], 1'b0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      in_valid = 1'b0; clr = 1'b0;
      #2 rst = 1'b0;
      #1 model_clear();
      check_all(tag);
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   initial begin
      string alpha = "JUSTMONIKA";
      rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_char = 8'h00;
      model_clear();
      #3 check_all("reset");
      @(posedge clk);
      #1 rst = 1'b1;

      feed("seq29", "AABABA__JUSTMONIKA__CDEDE");
      chk("seq29.pos", pos0, 32'd17);
      chk("seq29.cnt", cnt0, 32'd1);

      step("clr", 1'b0, 8'h00, 1'b1);
      feed("seq30", "ABABA");
      chk("seq30.cnt", cnt1, 32'd2);
      chk("seq30.pos", pos1, 32'd4);

      step("clr", 1'b0, 8'h00, 1'b1);
      feed("seq31", "JUSTMO");
      for (int i = 0; i < 3; i++) step("gap31", 1'b0, 8'h4E, 1'b0);
      chk("gap31.plen", pl0, 32'd6);
      feed("seq31", "NIKA");
      chk("seq31.pos", pos0, 32'd9);

      step("clr", 1'b0, 8'h00, 1'b1);
      feed("seq32", "JUSTMO");
      do_reset("rst32");
      feed("seq32", "NIKA");
      chk("seq32.cnt", cnt0, 32'd0);

      step("clr", 1'b0, 8'h00, 1'b1);
      feed("seq33", "AAAAA");
      chk("seq33.cnt", cnt2, 32'd3);
      chk("seq33.pos", pos2, 32'd0);

      step("clr", 1'b0, 8'h00, 1'b1);
      feed("seq34", "JUSTMONIK");
      step("seq34", 1'b1, 8'h41, 1'b1);
      chk("seq34.cnt", cnt0, 32'd0);
      chk("seq34.plen", pl0, 32'd0);

      step("zero", 1'b1, 8'h00, 1'b0);

      for (int n = 0; n < 3000; n++) begin
         int r;
         byte unsigned c;
         r = int'($urandom_range(0, 99));
         if (r < 60) c = (($urandom_range(0, 1) == 0) ? 8'h41 : 8'h42);
         else if (r < 90) c = alpha[$urandom_range(0, 9)];
         else if (r < 95) c = 8'h00;
         else c = 8'($urandom_range(0, 255));
         r = int'($urandom_range(0, 199));
         if (r < 4) step("rnd.clr", 1'b0, c, 1'b1);
         else if (r < 6) step("rnd.clrv", 1'b1, c, 1'b1);
         else if (r < 30) step("rnd.idle", 1'b0, c, 1'b0);
         else if (r < 32) do_reset("rnd.rst");
         else if (r < 36) feed("rnd.word", "JUSTMONIKA");
         else step("rnd", 1'b1, c, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total_n, bad_n);
      $finish;
   end

endmodule

// File: doc/char_matcher.md
CHAR_MATCHER -- requirements
Module: char_matcher

Interface
REQ-001 Parameter PAT_LEN, default 10, pattern length in characters, legal range 1..32.
REQ-002 Parameter PAT, default "JUSTMONIKA", a packed 8*PAT_LEN-bit ASCII pattern whose first character is in the MSB byte.
REQ-003 Parameter CNT_W, default 16, width of the match and position counters.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 clr  input  1  synchronous clear of the matcher state and both counters.
REQ-007 in_valid  input  1  qualifies in_char for the current cycle.
REQ-008 in_char  input  8  incoming ASCII character, most significant byte first in stream order.
REQ-009 match  output  1  one-cycle pulse, high when the accepted stream ends with a complete PAT occurrence.
REQ-010 match_pos  output  CNT_W  zero-based stream index of the character that completed the most recent match.
REQ-011 match_cnt  output  CNT_W  number of matches since the last reset or clear; saturates at its maximum.
REQ-012 prefix_len  output  $clog2(PAT_LEN+1)  length of the longest proper suffix of the accepted stream that is also a prefix of PAT.

Function
REQ-013 A character is accepted on a rising edge when in_valid=1 and clr=0; otherwise in_char is ignored.
REQ-014 The block keeps an internal accepted-character index that starts at 0 and increments by 1 per accepted character; it wraps modulo 2^CNT_W.
REQ-015 match shall be registered: it asserts in the cycle after the edge that accepts the completing character, and it deasserts after exactly 1 cycle unless the next accepted character also completes a match.
REQ-016 Matching shall allow overlap: a match is reported for every accepted character at which the last PAT_LEN accepted characters equal PAT.
REQ-017 prefix_len shall follow KMP semantics: after a mismatch it falls back through the pattern's failure function; after a full match it equals failure(PAT_LEN), never PAT_LEN.
REQ-018 The failure table shall be computed from PAT at elaboration time, with no runtime table-build cycles.
REQ-019 Each accepted character shall be resolved in a single cycle, including chained fallbacks; there is no backpressure and no stall.
REQ-020 On a match, match_pos is loaded with the index of the completing character; otherwise match_pos holds its value.
REQ-021 On a match, match_cnt increments by 1 if it is below 2^CNT_W-1, and otherwise holds at 2^CNT_W-1.
REQ-022 In cycles with in_valid=0, prefix_len, the internal index, match_pos and match_cnt all hold, and match is 0 in the following cycle.
REQ-023 clr=1 sets prefix_len, the index, match_pos and match_cnt to 0 and match to 0 at the next edge; when clr and in_valid are high together, clr wins and the character is discarded.
REQ-024 Any byte value, including 8'h00, is a legal character and is compared literally.
REQ-025 When PAT_LEN=1, every accepted character equal to PAT produces a match, and prefix_len stays 0.

Reset
REQ-026 Asserting rst (rst=0) shall immediately force match=0, match_pos=0, match_cnt=0, prefix_len=0 and the internal index to 0, regardless of clk.
REQ-027 Reset mid-pattern shall discard all partial-match progress; the first character accepted after reset release has index 0.
REQ-028 The block shall accept characters on the first rising edge after rst deasserts.

Verification
REQ-029 Default parameters; feed "AABABA__JUSTMONIKA__CDEDE" one character per cycle with in_valid=1 -> a single match pulse one cycle after index 17 ('A') is accepted; final state match_pos=17, match_cnt=1.
REQ-030 PAT="ABA", PAT_LEN=3; feed "ABABA" -> prefix_len sequence 1,2,1,2,1; matches at indices 2 and 4; match_cnt=2.
REQ-031 Default parameters; "JUSTMO", then 3 cycles of in_valid=0, then "NIKA" -> prefix_len holds at 6 during the gap; match pulses with match_pos=9.
REQ-032 Default parameters; "JUSTMO", then rst pulse, then "NIKA" -> prefix_len=0 after reset; no match; match_cnt=0.
REQ-033 PAT="A", PAT_LEN=1, CNT_W=2; feed "AAAAA" -> match high for 5 consecutive cycles; match_cnt saturates at 3; match_pos=0,1,2,3,0 (index wrap).
REQ-034 Default parameters; "JUSTMONIK", then 'A' with clr=1 in the same cycle -> no match; all counters 0; prefix_len=0.
